mem_access_stage: RTL and testbench

- Memory stage of the 5-stage pipeline. Sits between the execute/memory latch outputs and the memory/writeback latch inputs.
- Issues LW/SW accesses to a variable-latency data memory over a req/ack handshake.
- Stalls upstream stages while an access is outstanding and inserts nops into writeback during the stall.
- Non-memory instructions pass straight through in zero cycles.

---
 rtl/mem_access_stage.sv | 148 ++++++++++++++
 tb/tb_mem_access_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Memory stage of the 5-stage pipeline. Non-memory instructions pass through
//   combinationally. LW/SW are issued to a variable-latency data memory over a
//   registered req/ack handshake; upstream is stalled and nops are sent to
//   writeback until the access completes or times out.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   ir_in, o_in, b_in   instruction, ALU result/address, store data (X/M latch)
//   dmem_ack, dmem_rdata  memory completion pulse and load data
//   ir_out, o_out, d_out  instruction, ALU result, load data (M/W latch)
//   stall               freeze PC and upstream latches this cycle
//   dmem_req, dmem_we, dmem_addr, dmem_wdata  registered memory request
//   err                 sticky timeout flag
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int          ADDR_W  = 12,
    parameter int          TIMEOUT = 16,
    parameter logic [4:0]  OP_LW   = 5'b01000,
    parameter logic [4:0]  OP_SW   = 5'b00111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ir_in,
    input  logic [31:0]       o_in,
    input  logic [31:0]       b_in,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       ir_out,
    output logic [31:0]       o_out,
    output logic [31:0]       d_out,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [31:0] h_ir, h_o, h_d;
    logic [7:0]  cnt;

    logic [4:0] op;
    logic       memop;
    logic       held_is_lw;
    logic       timeout_hit;

    assign op          = ir_in[31:27];
    assign memop       = (op == OP_LW) || (op == OP_SW);
    assign held_is_lw  = (h_ir[31:27] == OP_LW);
    assign timeout_hit = (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Ack reaches stall only through this transition, never combinationally.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (memop) next_state = BUSY;
            BUSY:    if (dmem_ack || timeout_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path through
    // this block can leave a value unassigned and infer a latch.
    always_comb begin
        ir_out = '0;
        o_out  = '0;
        d_out  = '0;
        stall  = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    stall = 1'b1;              // nop bubble while issuing
                end else begin
                    ir_out = ir_in;
                    o_out  = o_in;
                end
            end
            BUSY: stall = 1'b1;
            DONE: begin
                ir_out = h_ir;
                o_out  = h_o;
                d_out  = h_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_ir       <= '0;
            h_o        <= '0;
            h_d        <= '0;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        h_ir       <= ir_in;
                        h_o        <= o_in;
                        h_d        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= (op == OP_SW);
                        dmem_addr  <= o_in[ADDR_W-1:0];
                        dmem_wdata <= b_in;
                        cnt        <= '0;
                    end
                end
                BUSY: begin
                    // Ack has priority over a simultaneous timeout.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (held_is_lw) h_d <= dmem_rdata;
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        h_ir     <= '0;
                        h_o      <= '0;
                        h_d      <= '0;
                        err      <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;   // acks in IDLE/DONE are ignored
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed, self-checking bench for mem_access_stage. Inputs are driven and
//   outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam logic [31:0] I_ADD  = 32'h0000_0000;
    localparam logic [31:0] I_ADD2 = 32'h0862_0000;   // op 00001, not a memop
    localparam logic [31:0] I_LW   = 32'h4022_0004;   // op 01000
    localparam logic [31:0] I_LW2  = 32'h4044_0008;
    localparam logic [31:0] I_SW   = 32'h3822_0010;   // op 00111

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir_in, o_in, b_in, dmem_rdata;
    logic        dmem_ack;
    logic [31:0] ir_out, o_out, d_out, dmem_wdata;
    logic        stall, dmem_req, dmem_we, err;
    logic [11:0] dmem_addr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(12), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .ir_in      (ir_in),
        .o_in       (o_in),
        .b_in       (b_in),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .ir_out     (ir_out),
        .o_out      (o_out),
        .d_out      (d_out),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .err        (err)
    );

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; ir_in = I_ADD; o_in = 32'h55; b_in = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        n_total++; if (dmem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", dmem_req); else n_pass++;
        n_total++; if (dmem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", dmem_we); else n_pass++;
        n_total++; if (dmem_addr !== 12'h0) $display("FAIL rst_addr: got %h want 000", dmem_addr); else n_pass++;
        n_total++; if (dmem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", dmem_wdata); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (ir_out !== I_ADD) $display("FAIL add_ir: got %h want %h", ir_out, I_ADD); else n_pass++;
        n_total++; if (o_out !== 32'h55) $display("FAIL add_o: got %h want 55", o_out); else n_pass++;
        n_total++; if (d_out !== 32'h0) $display("FAIL add_d: got %h want 0", d_out); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL add_stall: got %b want 0", stall); else n_pass++;
    endtask

    task automatic test_lw();
        ir_in = I_LW; o_in = 32'h0000_0A04; b_in = 32'hFFFF_FFFF;
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL lw_stall_idle: got %b want 1", stall); else n_pass++;
        n_total++; if (ir_out !== 32'h0) $display("FAIL lw_bubble_ir: got %h want 0", ir_out); else n_pass++;
        next_cycle();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL lw_stall_busy: got %b want 1", stall); else n_pass++;
        n_total++; if (dmem_req !== 1'b1) $display("FAIL lw_req: got %b want 1", dmem_req); else n_pass++;
        n_total++; if (dmem_we !== 1'b0) $display("FAIL lw_we: got %b want 0", dmem_we); else n_pass++;
        n_total++; if (dmem_addr !== 12'hA04) $display("FAIL lw_addr: got %h want a04", dmem_addr); else n_pass++;
        next_cycle();
        dmem_ack = 1'b0; dmem_rdata = '0;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL lw_stall_done: got %b want 0", stall); else n_pass++;
        n_total++; if (d_out !== 32'hDEAD_BEEF) $display("FAIL lw_data: got %h want deadbeef", d_out); else n_pass++;
        n_total++; if (ir_out !== I_LW) $display("FAIL lw_ir_done: got %h want %h", ir_out, I_LW); else n_pass++;
        n_total++; if (o_out !== 32'hA04) $display("FAIL lw_o_done: got %h want a04", o_out); else n_pass++;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL lw_req_done: got %b want 0", dmem_req); else n_pass++;
        ir_in = I_ADD;
        next_cycle();
    endtask

    task automatic test_sw_delayed();
        int n_stall = 0;
        ir_in = I_SW; o_in = 32'h10; b_in = 32'h1234_5678;
        #1;
        if (stall === 1'b1) n_stall++;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            // Upstream operands change; the registered request must not.
            o_in = 32'hABCD_E000 + 32'(k); b_in = 32'h5555_0000 + 32'(k);
            dmem_ack = (k == 4);
            #1;
            if (stall === 1'b1) n_stall++;
            n_total++; if (dmem_req !== 1'b1) $display("FAIL sw_req_%0d: got %b want 1", k, dmem_req); else n_pass++;
            n_total++; if (dmem_we !== 1'b1) $display("FAIL sw_we_%0d: got %b want 1", k, dmem_we); else n_pass++;
            n_total++; if (dmem_addr !== 12'h010) $display("FAIL sw_addr_%0d: got %h want 010", k, dmem_addr); else n_pass++;
            n_total++; if (dmem_wdata !== 32'h1234_5678) $display("FAIL sw_wdata_%0d: got %h want 12345678", k, dmem_wdata); else n_pass++;
        end
        next_cycle();
        dmem_ack = 1'b0;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL sw_stall_done: got %b want 0", stall); else n_pass++;
        n_total++; if (n_stall !== 6) $display("FAIL sw_stall_count: got %0d want 6", n_stall); else n_pass++;
        n_total++; if (d_out !== 32'h0) $display("FAIL sw_d_done: got %h want 0", d_out); else n_pass++;
        n_total++; if (ir_out !== I_SW) $display("FAIL sw_ir_done: got %h want %h", ir_out, I_SW); else n_pass++;
        n_total++; if (o_out !== 32'h10) $display("FAIL sw_o_done: got %h want 10", o_out); else n_pass++;
        ir_in = I_ADD; o_in = '0; b_in = '0;
        next_cycle();
    endtask

    task automatic test_timeout();
        int n_stall = 0;
        ir_in = I_LW2; o_in = 32'h20;
        #1;
        n_total++; if (err !== 1'b0) $display("FAIL to_err_before: got %b want 0", err); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            if (i != 0) #1;
            if (stall !== 1'b1) break;
            n_stall++;
            next_cycle();
        end
        // 1 IDLE issue cycle + 16 BUSY cycles.
        n_total++; if (n_stall !== 17) $display("FAIL to_stall_count: got %0d want 17", n_stall); else n_pass++;
        n_total++; if (ir_out !== 32'h0) $display("FAIL to_ir_nop: got %h want 0", ir_out); else n_pass++;
        n_total++; if (o_out !== 32'h0) $display("FAIL to_o_nop: got %h want 0", o_out); else n_pass++;
        n_total++; if (d_out !== 32'h0) $display("FAIL to_d_nop: got %h want 0", d_out); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL to_err_set: got %b want 1", err); else n_pass++;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL to_req_drop: got %b want 0", dmem_req); else n_pass++;
        ir_in = I_ADD2; o_in = 32'h99;
        next_cycle();
        #1;
        n_total++; if (err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", err); else n_pass++;
        n_total++; if (ir_out !== I_ADD2) $display("FAIL to_pass_ir: got %h want %h", ir_out, I_ADD2); else n_pass++;
        n_total++; if (o_out !== 32'h99) $display("FAIL to_pass_o: got %h want 99", o_out); else n_pass++;
    endtask

    task automatic test_reset_mid_busy();
        ir_in = I_LW; o_in = 32'h30;
        next_cycle();   // BUSY 1
        next_cycle();   // BUSY 2
        next_cycle();   // BUSY 3
        n_total++; if (dmem_req !== 1'b1) $display("FAIL rb_req_busy: got %b want 1", dmem_req); else n_pass++;
        reset = 1'b0;
        next_cycle();
        reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        ir_in = I_ADD2; o_in = 32'h77;
        #1;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL rb_req_reset: got %b want 0", dmem_req); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rb_err_clear: got %b want 0", err); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL rb_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (ir_out !== I_ADD2) $display("FAIL rb_ir: got %h want %h", ir_out, I_ADD2); else n_pass++;
        next_cycle();
        dmem_ack = 1'b0; dmem_rdata = '0;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL rb_late_ack_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL rb_late_ack_req: got %b want 0", dmem_req); else n_pass++;
        n_total++; if (o_out !== 32'h77) $display("FAIL rb_late_ack_o: got %h want 77", o_out); else n_pass++;
        n_total++; if (d_out !== 32'h0) $display("FAIL rb_late_ack_d: got %h want 0", d_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr [2];
        logic [31:0] addr  [2];
        logic [31:0] data  [2];
        instr[0] = I_LW;  addr[0] = 32'h100; data[0] = 32'h1111_1111;
        instr[1] = I_LW2; addr[1] = 32'h104; data[1] = 32'h2222_2222;
        for (int i = 0; i < 2; i++) begin
            ir_in = instr[i]; o_in = addr[i];
            #1;
            n_total++; if (stall !== 1'b1) $display("FAIL b2b_stall0_%0d: got %b want 1", i, stall); else n_pass++;
            next_cycle();
            dmem_ack = 1'b1; dmem_rdata = data[i];
            #1;
            n_total++; if (stall !== 1'b1) $display("FAIL b2b_stall1_%0d: got %b want 1", i, stall); else n_pass++;
            n_total++; if (dmem_req !== 1'b1) $display("FAIL b2b_req_%0d: got %b want 1", i, dmem_req); else n_pass++;
            n_total++; if (dmem_addr !== addr[i][11:0]) $display("FAIL b2b_addr_%0d: got %h want %h", i, dmem_addr, addr[i][11:0]); else n_pass++;
            next_cycle();
            dmem_ack = 1'b0; dmem_rdata = '0;
            #1;
            n_total++; if (stall !== 1'b0) $display("FAIL b2b_stall2_%0d: got %b want 0", i, stall); else n_pass++;
            n_total++; if (d_out !== data[i]) $display("FAIL b2b_data_%0d: got %h want %h", i, d_out, data[i]); else n_pass++;
            n_total++; if (ir_out !== instr[i]) $display("FAIL b2b_ir_%0d: got %h want %h", i, ir_out, instr[i]); else n_pass++;
            next_cycle();
        end
        ir_in = I_ADD; o_in = '0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_delayed();
        test_timeout();
        test_reset_mid_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
